ascii_to_ps2_tx: RTL

Keyboard-side PS/2 emulator. Accepts one ASCII character per handshake, translates it to a PS/2 scan-code-set-2 make code, and serially transmits a full keystroke (make code, 0xF0, make code) on ps2_clk/ps2_data, acting as the device end of the link. It feeds the PS/2 receive path and scancode-to-ASCII decoding for loopback testing and simulated keyboard input.

---
 rtl/ascii_to_ps2_tx.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ascii_to_ps2_tx.sv
// Device-side PS/2 keystroke generator: one ASCII character in, make/break/make
// scan-code-set-2 frames out on ps2_clk/ps2_data.
`timescale 1ns/1ps
module ascii_to_ps2_tx #(
    parameter int unsigned CLK_HALF   = 2000,
    parameter int unsigned GAP_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       busy,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int unsigned MAX_CNT = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       BREAK_CODE = 8'hF0;
    localparam logic [3:0]       LAST_BIT   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       seq_q, seq_d;
    logic [7:0]       code_q, code_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             low_q, low_d;
    logic             ps2_clk_q, ps2_clk_d;
    logic             ps2_data_q, ps2_data_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [8:0]       map_c;
    logic [7:0]       cur_byte_c;

    // {mapped, make code}; letters are folded to upper case first
    function automatic logic [8:0] ascii_to_make(input logic [7:0] ch);
        logic [7:0] up;
        logic [8:0] res;
        up  = ((ch >= 8'h61) && (ch <= 8'h7A)) ? (ch - 8'h20) : ch;
        res = 9'h000;
        case (up)
            8'h41: res = {1'b1, 8'h1C};
            8'h42: res = {1'b1, 8'h32};
            8'h43: res = {1'b1, 8'h21};
            8'h44: res = {1'b1, 8'h23};
            8'h45: res = {1'b1, 8'h24};
            8'h46: res = {1'b1, 8'h2B};
            8'h47: res = {1'b1, 8'h34};
            8'h48: res = {1'b1, 8'h33};
            8'h49: res = {1'b1, 8'h43};
            8'h4A: res = {1'b1, 8'h3B};
            8'h4B: res = {1'b1, 8'h42};
            8'h4C: res = {1'b1, 8'h4B};
            8'h4D: res = {1'b1, 8'h3A};
            8'h4E: res = {1'b1, 8'h31};
            8'h4F: res = {1'b1, 8'h44};
            8'h50: res = {1'b1, 8'h4D};
            8'h51: res = {1'b1, 8'h15};
            8'h52: res = {1'b1, 8'h2D};
            8'h53: res = {1'b1, 8'h1B};
            8'h54: res = {1'b1, 8'h2C};
            8'h55: res = {1'b1, 8'h3C};
            8'h56: res = {1'b1, 8'h2A};
            8'h57: res = {1'b1, 8'h1D};
            8'h58: res = {1'b1, 8'h22};
            8'h59: res = {1'b1, 8'h35};
            8'h5A: res = {1'b1, 8'h1A};
            8'h30: res = {1'b1, 8'h45};
            8'h31: res = {1'b1, 8'h16};
            8'h32: res = {1'b1, 8'h1E};
            8'h33: res = {1'b1, 8'h26};
            8'h34: res = {1'b1, 8'h25};
            8'h35: res = {1'b1, 8'h2E};
            8'h36: res = {1'b1, 8'h36};
            8'h37: res = {1'b1, 8'h3D};
            8'h38: res = {1'b1, 8'h3E};
            8'h39: res = {1'b1, 8'h46};
            8'h20: res = {1'b1, 8'h29};
            default: res = 9'h000;
        endcase
        return res;
    endfunction

    // Bit k of an 11-bit frame: start, data LSB first, odd parity, stop
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] k);
        logic v;
        case (k)
            4'd0:    v = 1'b0;
            4'd9:    v = ~^b;
            4'd10:   v = 1'b1;
            default: v = b[3'(k - 4'd1)];
        endcase
        return v;
    endfunction

    assign map_c      = ascii_to_make(in_char);
    assign cur_byte_c = (seq_q == 2'd1) ? BREAK_CODE : code_q;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        code_d     = code_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        low_d      = low_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    if (map_c[8]) begin
                        code_d     = map_c[7:0];
                        seq_d      = 2'd0;
                        bit_d      = 4'd0;
                        cnt_d      = '0;
                        low_d      = 1'b0;
                        ps2_data_d = 1'b0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = ST_FRAME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_FRAME: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        low_d     = 1'b1;
                        ps2_clk_d = 1'b0;
                    end else begin
                        // end of a low phase: next bit's data goes out with clk high
                        low_d     = 1'b0;
                        ps2_clk_d = 1'b1;
                        if (bit_q == LAST_BIT) begin
                            ps2_data_d = 1'b1;
                            state_d    = ST_GAP;
                        end else begin
                            bit_d      = bit_q + 4'd1;
                            ps2_data_d = frame_bit(cur_byte_c, bit_q + 4'd1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (seq_q == 2'd2) begin
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        seq_d      = seq_q + 2'd1;
                        bit_d      = 4'd0;
                        low_d      = 1'b0;
                        ps2_data_d = 1'b0;
                        state_d    = ST_FRAME;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            seq_q      <= 2'd0;
            code_q     <= 8'h00;
            bit_q      <= 4'd0;
            cnt_q      <= '0;
            low_q      <= 1'b0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            code_q     <= code_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            low_q      <= low_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;

endmodule
